uart_regmap_arbiter: RTL and testbench
======================================

// Module: uart_regmap_arbiter
// PURPOSE
//  Two-requester round-robin arbiter in front of the single-port 8-bit UART register/ROM memory.
//  Requester 0: UART command decoder (host). Requester 1: internal frame engine.
//  Decodes each access against the address map (RES_M/OP_F/PR/FR/FR_PR).
//  Blocks writes to the reserved region and flags unmapped addresses as errors.
//  Sequences the memory port with a fixed 2-cycle latency.
// PARAMETERS
//  DATA_W   8      memory data width
//  ADDR_W   8      memory address width
//  MAP_END  8'h4a  last mapped address; addr > MAP_END is unmapped
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       synchronous reset, active-low
//  reqN_valid    in   1       N=0,1: request valid, held until accepted
//  reqN_ready    out  1       N=0,1: request accepted this cycle
//  reqN_we       in   1       1=write, 0=read
//  reqN_addr     in   ADDR_W  access address
//  reqN_wdata    in   DATA_W  write data
//  rspN_valid    out  1       1-cycle response pulse
//  rspN_rdata    out  DATA_W  read data; 0 on write or error
//  rspN_err      out  1       access rejected; valid with rspN_valid
//  mem_en        out  1       memory access strobe
//  mem_we        out  1       memory write enable
//  mem_addr      out  ADDR_W  memory address
//  mem_wdata     out  DATA_W  memory write data
//  mem_rdata     in   DATA_W  read data, valid 1 cycle after mem_en & !mem_we
//  region        out  3       region of the current access: 0 RES_M, 1 OP_F, 2 PR, 3 FR, 4 FR_PR, 7 unmapped
//  err_cnt       out  8       saturating rejected-access count (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; rr_last=1, so req0 wins the first tie.
//  FSM states:
//   - IDLE -> ACCESS: on any reqN_valid.
//   - ACCESS -> RESP: unconditional.
//   - RESP -> IDLE: unconditional.
//  Accept (IDLE, cycle T):
//   - Winner is the sole valid requester, or !rr_last when both are valid.
//   - reqN_ready=1 for the winner only. Ready is a combinational function of valid and state.
//   - Latch we, addr, wdata and grant id. rr_last <= winner.
//  ACCESS (cycle T+1): decode region from the latched addr. Region ranges:
//   - RES_M: 0x00-0x07
//   - OP_F: 0x08-0x18
//   - PR: 0x19-0x28
//   - FR: 0x29-0x3f
//   - FR_PR: 0x40-MAP_END
//   - unmapped: 0x4b-0xff
//  ACCESS outputs:
//   - Reject when addr is unmapped, or we=1 with region RES_M.
//   - Legal access: mem_en=1, mem_we=we, mem_addr/mem_wdata from the latch.
//   - Rejected access: mem_en stays 0.
//   - region is valid in ACCESS and RESP; otherwise it holds its last value.
//  RESP (cycle T+2): rspG_valid=1 for the granted requester only.
//   - rspG_rdata = mem_rdata for a legal read, else 0.
//   - rspG_err = reject flag.
//  Latency and throughput:
//   - Request-to-response latency is exactly 2 cycles.
//   - Peak throughput is one access per 3 cycles. No accept happens in ACCESS or RESP.
//  Boundaries:
//   - A requester that deasserts valid before ready is not served.
//   - Simultaneous requests alternate strictly.
//   - Address 0x4a is legal; 0x4b is an error. Reads of RES_M are legal.
//  Reset mid-operation: FSM returns to IDLE immediately.
//   - The in-flight response is dropped; mem_en=0 on the next cycle.
//   - rr_last=1; err_cnt=0.
// CONFIGURATION
//  UART_ARB_ERR_CNT_EN defined:
//   - err_cnt increments in RESP for every rejected access.
//   - Saturates at 8'hff; cleared only by reset.
//  UART_ARB_ERR_CNT_EN undefined: err_cnt tied to 0 and no counter logic is built.
// TESTING
//  1. req0 read 0x10, mem_rdata=8'h5a:
//     - ready0 at T; mem_en=1, mem_we=0, addr=0x10 at T+1.
//     - rsp0_valid at T+2 with rdata=0x5a, err=0, region=1.
//  2. Both valid from reset, each streaming 3 writes:
//     - Grant order 0,1,0,1,0,1.
//     - mem_en seen every 3 cycles with matching addr/wdata.
//  3. req1 write 0x03 data 0xaa:
//     - mem_en stays 0; rsp1_valid at T+2 with err=1, region=0.
//     - err_cnt=1 with the macro defined, 0 without.
//  4. req0 read 0x4a -> legal, region=4.
//     req0 read 0x4b -> err=1, rdata=0, region=7, no mem_en.
//  5. rst_n low in the ACCESS cycle of a req0 read:
//     - No rsp0_valid.
//     - All outputs 0 on the next cycle.
//     - After release, a tie grants req0.
//  6. Macro defined, 300 rejected writes -> err_cnt holds 8'hff.

Source files
------------

// File: rtl/uart_regmap_arbiter.sv
// uart_regmap_arbiter: two-requester round-robin arbiter with address-map checks in front of the UART register/ROM port
// Ports: clk, rst_n (sync, active-low); req0_*/req1_* request channels (valid/ready/we/addr/wdata);
// rsp0_*/rsp1_* response pulses (valid/rdata/err); mem_* single-port memory (en/we/addr/wdata/rdata);
// region: decoded region of the current access; err_cnt: saturating rejected-access count.
// Optional feature: define UART_ARB_ERR_CNT_EN to build the err_cnt counter.
module uart_regmap_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int unsigned MAP_END = 'h4a
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        region,
  output logic [7:0]        err_cnt
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic rr_last, gnt, rej, rd, win, any, we, bad;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] wd;
  logic [2:0] reg_n;
  always_comb begin
    any = req0_valid | req1_valid;
    win = req1_valid & (!req0_valid | !rr_last);
    a = win ? req1_addr : req0_addr;
    we = win ? req1_we : req0_we;
    wd = win ? req1_wdata : req0_wdata;
    reg_n = a < ADDR_W'('h08) ? 3'd0 :
            a < ADDR_W'('h19) ? 3'd1 :
            a < ADDR_W'('h29) ? 3'd2 :
            a < ADDR_W'('h40) ? 3'd3 :
            a <= ADDR_W'(MAP_END) ? 3'd4 : 3'd7;
    bad = reg_n == 3'd7 || (we && reg_n == 3'd0);
    req0_ready = rst_n && state == IDLE && any && !win;
    req1_ready = rst_n && state == IDLE && win;
    rsp0_rdata = rsp0_valid && rd ? mem_rdata : '0;
    rsp1_rdata = rsp1_valid && rd ? mem_rdata : '0;
    rsp0_err = rsp0_valid & rej;
    rsp1_err = rsp1_valid & rej;
  end
  // the access is decoded while accepting so the ACCESS-cycle outputs come straight from registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_last <= 1'b1;
      gnt <= 1'b0;
      rej <= 1'b0;
      rd <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      region <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state <= ACCESS;
          rr_last <= win;
          gnt <= win;
          rej <= bad;
          rd <= !bad && !we;
          mem_en <= !bad;
          mem_we <= !bad && we;
          mem_addr <= a;
          mem_wdata <= wd;
          region <= reg_n;
        end
        ACCESS: begin
          state <= RESP;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          rsp0_valid <= !gnt;
          rsp1_valid <= gnt;
        end
        RESP: begin
          state <= IDLE;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef UART_ARB_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt <= '0;
    else if (state == RESP && rej && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_uart_regmap_arbiter.sv
// tb_uart_regmap_arbiter: table, random and sequence checks of uart_regmap_arbiter against a reference model
module tb_uart_regmap_arbiter;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [7:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata, mem_addr, mem_wdata, err_cnt;
  logic [7:0] mem_rdata = 0;
  logic mem_en, mem_we;
  logic [2:0] region;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int total = 0, passes = 0, exp_cnt = 0;
`ifdef UART_ARB_ERR_CNT_EN
  localparam bit CNT_EN = 1;
`else
  localparam bit CNT_EN = 0;
`endif
  typedef struct {
    bit p;
    bit w;
    logic [7:0] a;
    logic [7:0] d;
    logic [2:0] r;
    bit e;
  } vec_t;
  vec_t tab [14];
  uart_regmap_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .region(region), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", n, act, exp);
  endtask
  function automatic logic [2:0] ref_region(input logic [7:0] a);
    int lo [5] = '{'h00, 'h08, 'h19, 'h29, 'h40};
    if (a > 8'h4a) return 3'd7;
    for (int i = 4; i >= 0; i--) if (int'(a) >= lo[i]) return 3'(i);
    return 3'd7;
  endfunction
  task automatic do_reset();
    rst_n = 0;
    req0_valid = 0;
    req1_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err,
                          mem_en, mem_we, mem_addr, mem_wdata, region, err_cnt}, 64'd0);
    rst_n = 1;
    exp_cnt = 0;
  endtask
  task automatic do_single(input bit p, input bit w, input logic [7:0] a, input logic [7:0] d,
                           input logic [2:0] er, input bit ee);
    logic [7:0] exp_rd;
    @(negedge clk);
    if (p) begin req1_valid = 1; req1_we = w; req1_addr = a; req1_wdata = d; end
    else begin req0_valid = 1; req0_we = w; req0_addr = a; req0_wdata = d; end
    #1;
    chk("ready", {req1_ready, req0_ready}, p ? 2'b10 : 2'b01);
    @(posedge clk);
    #1;
    req0_valid = 0;
    req1_valid = 0;
    chk("mem_en", mem_en, !ee);
    if (!ee) chk("mem_bus", {mem_we, mem_addr, mem_wdata}, {w, a, d});
    chk("region_access", region, er);
    exp_rd = (!ee && !w) ? ref_mem[a] : 8'h00;
    @(posedge clk);
    #1;
    chk("rsp_valid", {rsp1_valid, rsp0_valid}, p ? 2'b10 : 2'b01);
    chk("rsp_err", p ? rsp1_err : rsp0_err, ee);
    chk("rsp_rdata", p ? rsp1_rdata : rsp0_rdata, exp_rd);
    chk("region_resp", region, er);
    chk("mem_en_resp", mem_en, 0);
    if (!ee && w) ref_mem[a] = d;
    if (ee && CNT_EN && exp_cnt < 255) exp_cnt++;
    @(posedge clk);
    #1;
    chk("rsp_idle", {rsp1_valid, rsp0_valid}, 0);
    chk("err_cnt", err_cnt, exp_cnt);
  endtask
  initial begin
    logic [7:0] s0a [4], s0d [4], s1a [4], s1d [4], pa, pd, ra;
    logic [2:0] rr;
    bit rw, rp, re;
    int i0, i1, k, en_seen, last_en;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 8'h5a;
    ref_mem[8'h10] = 8'h5a;
    tab[0]  = '{0, 0, 8'h10, 8'h00, 3'd1, 0};
    tab[1]  = '{1, 1, 8'h03, 8'haa, 3'd0, 1};
    tab[2]  = '{0, 0, 8'h4a, 8'h00, 3'd4, 0};
    tab[3]  = '{0, 0, 8'h4b, 8'h00, 3'd7, 1};
    tab[4]  = '{1, 0, 8'h03, 8'h00, 3'd0, 0};
    tab[5]  = '{0, 1, 8'h08, 8'h77, 3'd1, 0};
    tab[6]  = '{1, 0, 8'h08, 8'h00, 3'd1, 0};
    tab[7]  = '{0, 0, 8'h07, 8'h00, 3'd0, 0};
    tab[8]  = '{1, 1, 8'h18, 8'h12, 3'd1, 0};
    tab[9]  = '{0, 1, 8'h19, 8'h34, 3'd2, 0};
    tab[10] = '{1, 0, 8'h28, 8'h00, 3'd2, 0};
    tab[11] = '{0, 1, 8'h29, 8'h56, 3'd3, 0};
    tab[12] = '{1, 1, 8'h3f, 8'h9c, 3'd3, 0};
    tab[13] = '{0, 1, 8'hff, 8'h01, 3'd7, 1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s0a[i] = 8'h20 + 8'(i); s0d[i] = 8'($urandom);
      s1a[i] = 8'h30 + 8'(i); s1d[i] = 8'($urandom);
    end
    s0a[3] = 0; s0d[3] = 0; s1a[3] = 0; s1d[3] = 0;
    i0 = 0; i1 = 0; k = 0; en_seen = 0; last_en = -1; pa = 0; pd = 0;
    for (int c = 0; c < 60 && en_seen < 6; c++) begin
      @(negedge clk);
      req0_valid = i0 < 3; req0_we = 1; req0_addr = s0a[i0]; req0_wdata = s0d[i0];
      req1_valid = i1 < 3; req1_we = 1; req1_addr = s1a[i1]; req1_wdata = s1d[i1];
      #1;
      if (mem_en) begin
        chk("stream_mem", {mem_we, mem_addr, mem_wdata}, {1'b1, pa, pd});
        if (last_en >= 0) chk("stream_gap", c - last_en, 3);
        last_en = c;
        en_seen++;
      end
      if (req0_ready || req1_ready) begin
        chk("stream_grant", {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
        pa = req1_ready ? s1a[i1] : s0a[i0];
        pd = req1_ready ? s1d[i1] : s0d[i0];
        ref_mem[pa] = pd;
        if (req1_ready) i1++;
        else i0++;
        k++;
      end
    end
    chk("stream_done", en_seen, 6);
    req0_valid = 0;
    req1_valid = 0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 14; i++) do_single(tab[i].p, tab[i].w, tab[i].a, tab[i].d, tab[i].r, tab[i].e);
    for (int i = 0; i < 40; i++) begin
      rp = 1'($urandom);
      rw = 1'($urandom);
      ra = ($urandom % 2) ? 8'($urandom_range(0, 255)) : 8'($urandom_range('h00, 'h4f));
      rr = ref_region(ra);
      re = rr == 3'd7 || (rw && rr == 3'd0);
      do_single(rp, rw, ra, 8'($urandom), rr, re);
    end
    @(negedge clk);
    req0_valid = 1; req0_we = 0; req0_addr = 8'h20;
    #1;
    chk("drop_ready0", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 0;
    req1_valid = 1; req1_we = 0; req1_addr = 8'h21;
    #1;
    chk("drop_ready1_access", req1_ready, 0);
    @(posedge clk);
    #1;
    chk("drop_ready1_resp", req1_ready, 0);
    chk("drop_rsp0", rsp0_valid, 1);
    req1_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("drop_not_served", {mem_en, rsp1_valid, req1_ready}, 0);
    @(negedge clk);
    req0_valid = 1; req0_we = 0; req0_addr = 8'h10;
    @(posedge clk);
    #1;
    req0_valid = 0;
    chk("rst_access_en", mem_en, 1);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("rst_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err,
                        mem_en, mem_we, mem_addr, mem_wdata, region, err_cnt}, 64'd0);
    rst_n = 1;
    exp_cnt = 0;
    @(posedge clk);
    #1;
    chk("rst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    @(negedge clk);
    req0_valid = 1; req0_addr = 8'h11; req1_valid = 1; req1_addr = 8'h12;
    #1;
    chk("rst_tie_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk);
    #1;
    req0_valid = 0;
    req1_valid = 0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 300; i++)
      do_single(i[0], 1, i[0] ? 8'h05 : 8'hc0, 8'($urandom), i[0] ? 3'd0 : 3'd7, 1);
    chk("err_cnt_final", err_cnt, CNT_EN ? 8'hff : 8'h00);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
